palette_loader: RTL and testbench

PALETTE_LOADER -- requirements
Module: palette_loader

---
 rtl/gpu_pkg.sv | 16 +
 rtl/palette_loader.sv | 148 ++++++++++++++
 tb/tb_palette_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: palette address geometry and the palette loader state encoding.
package gpu_pkg;

    localparam int PAL_ADDR_W = 10;
    localparam int PAL_IDX_W  = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        VRD   = 3'd3,
        VCMP  = 3'd4,
        FIN   = 3'd5
    } pl_state_t;

endpackage

// File: rtl/palette_loader.sv
// Copies (pal_count+1) palettes from a handshaked source into palette RAM, one word at a time.
// Optional read-back verification of every written word is enabled by PALETTE_LOADER_VERIFY_EN.
module palette_loader
    import gpu_pkg::*;
#(
    parameter int SRC_AW        = 16,
    parameter int WORDS_PER_PAL = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PAL_IDX_W-1:0]  pal_first,
    input  logic [PAL_IDX_W-1:0]  pal_count,
    input  logic [SRC_AW-1:0]     src_base,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  src_req,
    output logic [SRC_AW-1:0]     src_addr,
    input  logic                  src_ack,
    input  logic [15:0]           src_data,
    output logic                  pal_memenable,
    output logic                  pal_memwrite,
    output logic [PAL_ADDR_W-1:0] pal_memaddr,
    output logic [15:0]           pal_writedata,
    input  logic [15:0]           pal_memdata
);

    pl_state_t              state_reg, state_next;
    logic [10:0]            n_reg, n_next;
    logic [10:0]            total_reg, total_next;
    logic [PAL_IDX_W-1:0]   first_reg, first_next;
    logic [SRC_AW-1:0]      base_reg, base_next;
    logic [15:0]            data_reg, data_next;
    logic                   word_last;
    logic [PAL_ADDR_W-1:0]  dest_addr;

    assign word_last = ((n_reg + 11'd1) == total_reg);
    // Palette index selects a 32-word block; the 10-bit sum wraps from palette 31 to 0.
    assign dest_addr = {first_reg, {(PAL_ADDR_W-PAL_IDX_W){1'b0}}} + n_reg[PAL_ADDR_W-1:0];

`ifdef PALETTE_LOADER_VERIFY_EN
    logic error_reg, error_next;
    assign error = error_reg;
`else
    logic unused_memdata;
    assign unused_memdata = ^pal_memdata;
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            total_reg <= '0;
            first_reg <= '0;
            base_reg  <= '0;
            data_reg  <= '0;
`ifdef PALETTE_LOADER_VERIFY_EN
            error_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            total_reg <= total_next;
            first_reg <= first_next;
            base_reg  <= base_next;
            data_reg  <= data_next;
`ifdef PALETTE_LOADER_VERIFY_EN
            error_reg <= error_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        total_next = total_reg;
        first_next = first_reg;
        base_next  = base_reg;
        data_next  = data_reg;
`ifdef PALETTE_LOADER_VERIFY_EN
        error_next = error_reg;
`endif
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        first_next = pal_first;
                        base_next  = src_base;
                        total_next = 11'((32'(pal_count) + 32'd1) * WORDS_PER_PAL);
                        n_next     = '0;
`ifdef PALETTE_LOADER_VERIFY_EN
                        error_next = 1'b0;
`endif
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (src_ack) begin
                        // Odd words carry only blue in the low byte.
                        data_next  = n_reg[0] ? {8'h00, src_data[7:0]} : src_data;
                        state_next = WRITE;
                    end
                end
`ifdef PALETTE_LOADER_VERIFY_EN
                WRITE: state_next = VRD;
                VRD:   state_next = VCMP;
                VCMP: begin
                    if (pal_memdata != data_reg) begin
                        error_next = 1'b1;
                    end
                    if (word_last) begin
                        state_next = FIN;
                    end else begin
                        n_next     = n_reg + 11'd1;
                        state_next = FETCH;
                    end
                end
`else
                WRITE: begin
                    if (word_last) begin
                        state_next = FIN;
                    end else begin
                        n_next     = n_reg + 11'd1;
                        state_next = FETCH;
                    end
                end
`endif
                FIN:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == FIN);
    assign src_req       = (state_reg == FETCH);
    assign src_addr      = src_req ? (base_reg + SRC_AW'(n_reg)) : '0;
    assign pal_memwrite  = (state_reg == WRITE);
    assign pal_memenable = (state_reg == WRITE) || (state_reg == VRD);
    assign pal_memaddr   = pal_memenable ? dest_addr : '0;
    assign pal_writedata = pal_memwrite ? data_reg : '0;

endmodule

// File: tb/tb_palette_loader.sv
// Self-checking bench for palette_loader: source responder, palette RAM model and expected-image checks.
module tb_palette_loader;

    localparam int SRC_AW = 16;
    localparam int WPP    = 32;
`ifdef PALETTE_LOADER_VERIFY_EN
    localparam int VCYC = 2;
`else
    localparam int VCYC = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [4:0]  pal_first;
    logic [4:0]  pal_count;
    logic [15:0] src_base;
    logic        busy, done, error;
    logic        src_req;
    logic [15:0] src_addr;
    logic        src_ack;
    logic [15:0] src_data;
    logic        pal_memenable, pal_memwrite;
    logic [9:0]  pal_memaddr;
    logic [15:0] pal_writedata;
    logic [15:0] pal_memdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] pal_mem [0:1023];
    logic [9:0]  wr_log [$];
    int          done_cnt = 0;
    int          ack_delay = 0;
    bit          use_ab = 0;
    logic [15:0] ab_base = 16'h0100;
    bit          corrupt40 = 0;

    palette_loader #(.SRC_AW(SRC_AW), .WORDS_PER_PAL(WPP)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .pal_first(pal_first), .pal_count(pal_count), .src_base(src_base),
        .busy(busy), .done(done), .error(error),
        .src_req(src_req), .src_addr(src_addr), .src_ack(src_ack), .src_data(src_data),
        .pal_memenable(pal_memenable), .pal_memwrite(pal_memwrite),
        .pal_memaddr(pal_memaddr), .pal_writedata(pal_writedata), .pal_memdata(pal_memdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] src_word(input logic [15:0] a);
        if (use_ab) return 16'hAB00 + (a - ab_base);
        return (a * 16'd40503) ^ 16'h3C5A;
    endfunction

    // Source responder: acks after ack_delay waiting cycles; checks the request is held meanwhile.
    initial begin
        int          wait_cnt;
        logic [15:0] held_addr;
        src_ack = 1'b0;
        src_data = '0;
        wait_cnt = 0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            if (!src_req) begin
                src_ack = 1'b0;
                src_data = '0;
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) begin
                    held_addr = src_addr;
                end else begin
                    checks++;
                    if (src_addr !== held_addr) begin
                        errors++;
                        $display("FAIL src_addr_stable: got %h need %h", src_addr, held_addr);
                    end
                    checks++;
                    if (pal_memenable !== 1'b0) begin
                        errors++;
                        $display("FAIL no_write_before_ack: got enable %b need 0", pal_memenable);
                    end
                end
                src_ack = (wait_cnt == ack_delay);
                src_data = src_ack ? src_word(src_addr) : 16'h0000;
                wait_cnt++;
            end
        end
    end

    // Palette RAM model with one-cycle read latency and an optional corrupted location.
    initial begin
        pal_memdata = '0;
        forever begin
            @(negedge clk);
            if (pal_memenable && pal_memwrite) begin
                pal_mem[pal_memaddr] = pal_writedata;
                wr_log.push_back(pal_memaddr);
            end else if (pal_memenable) begin
                pal_memdata = (corrupt40 && pal_memaddr == 10'd40) ? ~pal_mem[pal_memaddr]
                                                                 : pal_mem[pal_memaddr];
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_pal();
        for (int i = 0; i < 1024; i++) pal_mem[i] = 16'hDEAD;
        wr_log.delete();
    endtask

    task automatic run_load(input logic [4:0] f, input logic [4:0] c, input logic [15:0] b,
                            input int d, input int mid, input bit exp_err, input string tag);
        int          n_words;
        int          k;
        int          lat;
        int          done0;
        bit          seen;
        logic [9:0]  a;
        logic [15:0] w;
        logic [15:0] e;
        n_words = (int'(c) + 1) * WPP;
        clear_pal();
        ack_delay = d;
        lat = -1;
        @(negedge clk);
        pal_first = f; pal_count = c; src_base = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done0 = done_cnt;
        k = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b need 1", tag, busy);
        end
        seen = 0;
        while (!seen && k < 20000) begin
            if (done) begin
                seen = 1;
                lat = k - 1;
            end else begin
                @(negedge clk);
                k++;
                start = (mid > 0 && k == mid);
                if (start) begin
                    pal_first = ~f; pal_count = 5'd7; src_base = ~b;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, k);
        end else begin
            checks++;
            if (lat != n_words * (2 + d + VCYC)) begin
                errors++;
                $display("FAIL %s latency: got %0d need %0d", tag, lat, n_words * (2 + d + VCYC));
            end
        end
        checks++;
        if (error !== exp_err) begin
            errors++;
            $display("FAIL %s error_flag: got %b need %b", tag, error, exp_err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done %b busy %b need 0 0", tag, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done_cnt - done0 != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d need 1", tag, done_cnt - done0);
        end
        checks++;
        if (wr_log.size() != n_words) begin
            errors++;
            $display("FAIL %s write_count: got %0d need %0d", tag, wr_log.size(), n_words);
        end
        for (int j = 0; j < n_words; j++) begin
            a = 10'((int'(f) * 32 + j) % 1024);
            w = src_word(b + 16'(j));
            e = (j % 2 == 1) ? {8'h00, w[7:0]} : w;
            if (j < wr_log.size()) begin
                checks++;
                if (wr_log[j] !== a) begin
                    errors++;
                    $display("FAIL %s write_order[%0d]: got addr %0d need %0d", tag, j, wr_log[j], a);
                end
            end
            checks++;
            if (pal_mem[a] !== e) begin
                errors++;
                $display("FAIL %s pal_word[%0d]: got %h need %h", tag, a, pal_mem[a], e);
            end
        end
        $display("load %s first=%0d count=%0d base=%h delay=%0d latency=%0d", tag, f, c, b, d, lat);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        pal_first = '0; pal_count = '0; src_base = '0;
        #12;
        checks++;
        if ({busy, done, error, src_req, pal_memenable, pal_memwrite} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b need 000000",
                     {busy, done, error, src_req, pal_memenable, pal_memwrite});
        end
        checks++;
        if (src_addr !== 16'h0 || pal_memaddr !== 10'h0 || pal_writedata !== 16'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h %h %h need 0 0 0", src_addr, pal_memaddr, pal_writedata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_basic();
        use_ab = 1; ab_base = 16'h0100;
        run_load(5'd3, 5'd0, 16'h0100, 0, 0, 1'b0, "basic_p3");
        use_ab = 0;
    endtask

    task automatic test_wrap();
        run_load(5'd31, 5'd1, 16'($urandom), 0, 0, 1'b0, "wrap_p31");
    endtask

    task automatic test_slow_ack();
        run_load(5'($urandom), 5'd0, 16'($urandom), 5, 0, 1'b0, "slow_ack");
    endtask

    task automatic test_abort();
        int          k;
        int          done0;
        logic [4:0]  f;
        logic [9:0]  a;
        f = 5'($urandom);
        clear_pal();
        ack_delay = 2;
        @(negedge clk);
        pal_first = f; pal_count = 5'd1; src_base = 16'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(src_req && wr_log.size() == 10) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 2000) begin
            errors++;
            $display("FAIL abort_reach_word10: timed out");
        end
        done0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || src_req !== 1'b0 || pal_memenable !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy %b req %b en %b need 0 0 0", busy, src_req, pal_memenable);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (wr_log.size() != 10 || done_cnt != done0) begin
            errors++;
            $display("FAIL abort_quiet: got writes %0d dones %0d need 10 0", wr_log.size(), done_cnt - done0);
        end
        for (int j = 10; j < 64; j += 53) begin
            a = 10'((int'(f) * 32 + j) % 1024);
            checks++;
            if (pal_mem[a] !== 16'hDEAD) begin
                errors++;
                $display("FAIL abort_untouched[%0d]: got %h need dead", a, pal_mem[a]);
            end
        end
        $display("abort at word 10 checked");
        run_load(5'($urandom), 5'd0, 16'($urandom), 1, 0, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid();
        int k;
        int wr0;
        clear_pal();
        ack_delay = 1;
        @(negedge clk);
        pal_first = 5'd9; pal_count = 5'd0; src_base = 16'h4000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(pal_memwrite && wr_log.size() >= 4) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        reset_n = 1'b0;
        #1;
        wr0 = wr_log.size();
        checks++;
        if ({busy, done, error, src_req, pal_memenable, pal_memwrite} !== 6'b0 ||
            src_addr !== 16'h0 || pal_memaddr !== 10'h0 || pal_writedata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b %h %h %h need all zero",
                     {busy, done, error, src_req, pal_memenable, pal_memwrite},
                     src_addr, pal_memaddr, pal_writedata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy: got %b need 0", busy);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (wr_log.size() != wr0) begin
            errors++;
            $display("FAIL reset_mid_reissue: got %0d writes need %0d", wr_log.size(), wr0);
        end
        $display("reset during write checked");
        run_load(5'd2, 5'd0, 16'h1234, 1, 20, 1'b0, "start_ignored");
    endtask

`ifdef PALETTE_LOADER_VERIFY_EN
    task automatic test_verify();
        corrupt40 = 1;
        run_load(5'd1, 5'd0, 16'($urandom), 0, 0, 1'b1, "verify_bad40");
        corrupt40 = 0;
        run_load(5'd1, 5'd0, 16'($urandom), 0, 0, 1'b0, "verify_clear");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_load(5'($urandom), 5'($urandom_range(0, 3)), 16'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 1) * 15, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_slow_ack();
        test_abort();
        test_reset_mid();
`ifdef PALETTE_LOADER_VERIFY_EN
        test_verify();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
